// File: rtl/ht_pair_decoder_if.sv
// ht_pair_decoder_if
//   Bundles the three buses of the pair decoder:
//   - serial input stream:  axiiv/axiid in, axiir back
//   - code-table write bus: tbl_we, tbl_addr, tbl_code, tbl_len, tbl_x, tbl_y
//   - decoded output:       axiov, x_val, y_val out, axior back
//   - linbits: escape extension width, sampled once per codeword.
//   The master modport is the environment side and the slave modport is the decoder side.
interface ht_pair_decoder_if #(
  parameter int MAX_BITS = 19,
  parameter int DEPTH    = 256
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic                axiiv;
  logic                axiid;
  logic                axiir;
  logic [3:0]          linbits;
  logic                tbl_we;
  logic [AW-1:0]       tbl_addr;
  logic [MAX_BITS-1:0] tbl_code;
  logic [4:0]          tbl_len;
  logic [3:0]          tbl_x;
  logic [3:0]          tbl_y;
  logic                axiov;
  logic                axior;
  logic signed [15:0]  x_val;
  logic signed [15:0]  y_val;

  modport master (
    output axiiv, axiid, linbits, tbl_we, tbl_addr, tbl_code, tbl_len, tbl_x, tbl_y, axior,
    input  axiir, axiov, x_val, y_val
  );

  modport slave (
    input  axiiv, axiid, linbits, tbl_we, tbl_addr, tbl_code, tbl_len, tbl_x, tbl_y, axior,
    output axiir, axiov, x_val, y_val
  );
endinterface

// File: rtl/ht_pair_decoder.sv
// ht_pair_decoder
//   Serial Huffman pair decoder.
//   - Bits arrive MSB-first on the input stream.
//   - Each accepted bit is matched against a loadable code table.
//   - After a codeword match, the decoder collects the optional escape
//     extension bits and the sign bits.
//   - It then presents a signed (x, y) pair on the output handshake.
// Ports:
//   clk  - clock, all logic on posedge
//   rst  - synchronous active-high reset; clears state and the table
//   bus  - ht_pair_decoder_if.slave (stream in, table write, pair out)
//   err  - one-cycle pulse when a codeword overflows MAX_BITS without a
//          match. Only present when the macro HT_CODE_ERR_EN is defined.
module ht_pair_decoder #(
  parameter int MAX_BITS = 19,
  parameter int DEPTH    = 256
) (
  input  logic               clk,
  input  logic               rst,
  ht_pair_decoder_if.slave   bus
`ifdef HT_CODE_ERR_EN
  ,
  output logic               err
`endif
);
  localparam logic [4:0] MAXN = 5'(MAX_BITS);

  typedef enum logic [2:0] {
    CODE = 3'd0,
    XLIN = 3'd1,
    XSGN = 3'd2,
    YLIN = 3'd3,
    YSGN = 3'd4,
    OUT  = 3'd5
  } state_t;

  state_t              state_q, state_d;
  logic [MAX_BITS-1:0] tbl_code_q [DEPTH];
  logic [4:0]          tbl_len_q  [DEPTH];
  logic [3:0]          tbl_x_q    [DEPTH];
  logic [3:0]          tbl_y_q    [DEPTH];
  logic [MAX_BITS-1:0] buf_q, buf_d;      // left-justified codeword prefix
  logic [4:0]          n_q, n_d;
  logic [3:0]          lb_q, lb_d;        // linbits latched at match
  logic [3:0]          cnt_q, cnt_d;      // extension bits taken so far
  logic [3:0]          x_abs_q, x_abs_d, y_abs_q, y_abs_d;
  logic [12:0]         x_lin_q, x_lin_d, y_lin_q, y_lin_d;
  logic                x_sgn_q, x_sgn_d, y_sgn_q, y_sgn_d;
  logic [15:0]         x_val_q, y_val_q;
  logic                axiov_q, axiir_q;
  logic                accept_s, hit_s, ovf_s, match_s;
  logic [3:0]          hit_x_s, hit_y_s;
  logic [MAX_BITS-1:0] cand_s, mask_s;

  // First extension/sign state for y, or OUT when y carries no bits.
  function automatic state_t y_entry(input logic [3:0] y_abs, input logic [3:0] lb);
    if (y_abs == 4'd15 && lb != 4'd0) return YLIN;
    else if (y_abs != 4'd0)           return YSGN;
    else                              return OUT;
  endfunction

  // First state after a codeword match.
  function automatic state_t x_entry(input logic [3:0] x_abs, input logic [3:0] y_abs,
                                     input logic [3:0] lb);
    if (x_abs == 4'd15 && lb != 4'd0) return XLIN;
    else if (x_abs != 4'd0)           return XSGN;
    else                              return y_entry(y_abs, lb);
  endfunction

  // Signed value = +/-(abs + lin).
  function automatic logic [15:0] pair_val(input logic [3:0] abs_v, input logic [12:0] lin_v,
                                           input logic sgn_v);
    logic [15:0] mag;
    mag = {12'd0, abs_v} + {3'd0, lin_v};
    return sgn_v ? (16'd0 - mag) : mag;
  endfunction

  assign accept_s = bus.axiiv && axiir_q;

  // Same-cycle table match of the prefix plus the incoming bit.
  // The loop runs downwards so that the lowest matching index wins.
  always_comb begin
    cand_s  = buf_q | ({bus.axiid, {(MAX_BITS-1){1'b0}}} >> n_q);
    mask_s  = ~({MAX_BITS{1'b1}} >> (n_q + 5'd1));
    hit_s   = 1'b0;
    hit_x_s = 4'd0;
    hit_y_s = 4'd0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      match_s = (tbl_len_q[i] == (n_q + 5'd1)) && (((cand_s ^ tbl_code_q[i]) & mask_s) == '0);
      hit_s   = match_s ? 1'b1        : hit_s;
      hit_x_s = match_s ? tbl_x_q[i]  : hit_x_s;
      hit_y_s = match_s ? tbl_y_q[i]  : hit_y_s;
    end
  end

  assign ovf_s = accept_s && (state_q == CODE) && !hit_s && ((n_q + 5'd1) == MAXN);

  // Next-state and datapath update of the decode FSM.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    n_d     = n_q;
    lb_d    = lb_q;
    cnt_d   = cnt_q;
    x_abs_d = x_abs_q;
    y_abs_d = y_abs_q;
    x_lin_d = x_lin_q;
    y_lin_d = y_lin_q;
    x_sgn_d = x_sgn_q;
    y_sgn_d = y_sgn_q;
    case (state_q)
      CODE: begin
        if (accept_s && hit_s) begin
          x_abs_d = hit_x_s;
          y_abs_d = hit_y_s;
          lb_d    = bus.linbits;
          buf_d   = '0;
          n_d     = 5'd0;
          cnt_d   = 4'd0;
          state_d = x_entry(hit_x_s, hit_y_s, bus.linbits);
        end else if (ovf_s) begin
          // Overflowed prefix: drop it and restart at the next bit.
          buf_d = '0;
          n_d   = 5'd0;
        end else if (accept_s) begin
          buf_d = cand_s;
          n_d   = n_q + 5'd1;
        end else begin
          buf_d = buf_q;
        end
      end
      XLIN: begin
        if (accept_s) begin
          x_lin_d = {x_lin_q[11:0], bus.axiid};
          if ((cnt_q + 4'd1) == lb_q) begin
            cnt_d   = 4'd0;
            state_d = XSGN;  // abs is 15, so the sign bit always follows
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      XSGN: begin
        if (accept_s) begin
          x_sgn_d = bus.axiid;
          state_d = y_entry(y_abs_q, lb_q);
        end else begin
          x_sgn_d = x_sgn_q;
        end
      end
      YLIN: begin
        if (accept_s) begin
          y_lin_d = {y_lin_q[11:0], bus.axiid};
          if ((cnt_q + 4'd1) == lb_q) begin
            cnt_d   = 4'd0;
            state_d = YSGN;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      YSGN: begin
        if (accept_s) begin
          y_sgn_d = bus.axiid;
          state_d = OUT;
        end else begin
          y_sgn_d = y_sgn_q;
        end
      end
      OUT: begin
        if (axiov_q && bus.axior) begin
          state_d = CODE;
          buf_d   = '0;
          n_d     = 5'd0;
          cnt_d   = 4'd0;
          x_lin_d = 13'd0;
          y_lin_d = 13'd0;
          x_sgn_d = 1'b0;
          y_sgn_d = 1'b0;
        end else begin
          state_d = OUT;
        end
      end
      default: begin
        state_d = CODE;
        buf_d   = '0;
        n_d     = 5'd0;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // FSM state, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CODE;
      buf_q   <= '0;
      n_q     <= 5'd0;
      lb_q    <= 4'd0;
      cnt_q   <= 4'd0;
      x_abs_q <= 4'd0;
      y_abs_q <= 4'd0;
      x_lin_q <= 13'd0;
      y_lin_q <= 13'd0;
      x_sgn_q <= 1'b0;
      y_sgn_q <= 1'b0;
      x_val_q <= 16'd0;
      y_val_q <= 16'd0;
      axiov_q <= 1'b0;
      axiir_q <= 1'b1;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      n_q     <= n_d;
      lb_q    <= lb_d;
      cnt_q   <= cnt_d;
      x_abs_q <= x_abs_d;
      y_abs_q <= y_abs_d;
      x_lin_q <= x_lin_d;
      y_lin_q <= y_lin_d;
      x_sgn_q <= x_sgn_d;
      y_sgn_q <= y_sgn_d;
      axiov_q <= (state_d == OUT);
      axiir_q <= (state_d != OUT);
      // Capture the pair on entry to OUT; the sign may arrive that same cycle.
      if (state_d == OUT && state_q != OUT) begin
        x_val_q <= pair_val(x_abs_d, x_lin_d, x_sgn_d);
        y_val_q <= pair_val(y_abs_d, y_lin_d, y_sgn_d);
      end else begin
        x_val_q <= x_val_q;
        y_val_q <= y_val_q;
      end
    end
  end

  // Code table storage. A write is visible to matches from the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_code_q[i] <= '0;
        tbl_len_q[i]  <= 5'd0;
        tbl_x_q[i]    <= 4'd0;
        tbl_y_q[i]    <= 4'd0;
      end
    end else if (bus.tbl_we) begin
      tbl_code_q[bus.tbl_addr] <= bus.tbl_code;
      tbl_len_q[bus.tbl_addr]  <= bus.tbl_len;
      tbl_x_q[bus.tbl_addr]    <= bus.tbl_x;
      tbl_y_q[bus.tbl_addr]    <= bus.tbl_y;
    end else begin
      tbl_len_q[bus.tbl_addr] <= tbl_len_q[bus.tbl_addr];
    end
  end

`ifdef HT_CODE_ERR_EN
  logic err_q;

  // Overflow error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= ovf_s;
    end
  end

  assign err = err_q;
`endif

  assign bus.axiir = axiir_q;
  assign bus.axiov = axiov_q;
  assign bus.x_val = x_val_q;
  assign bus.y_val = y_val_q;
endmodule

// File: tb/tb_ht_pair_decoder.sv
// tb_ht_pair_decoder
//   Directed scoreboard bench for ht_pair_decoder.
//   - The DUT is built with MAX_BITS=4 so that the overflow path is short.
//   - Expected pairs are queued when their bits are driven.
//   - Each queued pair is popped and compared when the DUT presents it.
//   - The err pulse is also checked when HT_CODE_ERR_EN is defined.
module tb_ht_pair_decoder;
  localparam int MB = 4;
  localparam int DP = 16;
  localparam int AW = $clog2(DP);

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] y;
  } pair_t;

  logic  clk = 1'b0;
  logic  rst;
  pair_t sb[$];
  int    vectors = 0;
  int    miscompares = 0;

  always #5 clk = ~clk;

  ht_pair_decoder_if #(.MAX_BITS(MB), .DEPTH(DP)) bus ();

`ifdef HT_CODE_ERR_EN
  logic err;
  ht_pair_decoder #(.MAX_BITS(MB), .DEPTH(DP)) dut (.clk(clk), .rst(rst), .bus(bus), .err(err));
`else
  ht_pair_decoder #(.MAX_BITS(MB), .DEPTH(DP)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int a, input logic [MB-1:0] code, input logic [4:0] len,
                    input logic [3:0] x, input logic [3:0] y);
    bus.tbl_we   = 1'b1;
    bus.tbl_addr = AW'(a);
    bus.tbl_code = code;
    bus.tbl_len  = len;
    bus.tbl_x    = x;
    bus.tbl_y    = y;
    tick();
    bus.tbl_we   = 1'b0;
  endtask

  task automatic load_table();
    wr(0, 4'b1000, 5'd1, 4'd0,  4'd0);
    wr(1, 4'b0010, 5'd3, 4'd1,  4'd1);
    wr(2, 4'b0100, 5'd2, 4'd15, 4'd0);
  endtask

  // Drives nb bits MSB-first and returns #1 after the last one is accepted.
  task automatic send_bits(input logic [15:0] bits, input int nb);
    int budget;
    for (int i = nb - 1; i >= 0; i--) begin
      bus.axiiv = 1'b1;
      bus.axiid = bits[i];
      budget = 50;
      while (bus.axiir !== 1'b1 && budget > 0) begin
        tick();
        budget--;
      end
      if (budget == 0) begin
        check("accept_timeout", {31'd0, bus.axiir}, 32'd1);
      end
      tick();
    end
    bus.axiiv = 1'b0;
  endtask

  // Call right after the final bit is accepted: the pair must already be valid.
  task automatic check_pair(input string tag);
    pair_t e;
    e = sb.pop_front();
    check({tag, "_axiov"}, {31'd0, bus.axiov}, 32'd1);
    check({tag, "_x"}, {16'd0, bus.x_val}, {16'd0, e.x});
    check({tag, "_y"}, {16'd0, bus.y_val}, {16'd0, e.y});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish, expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    bus.axiiv = 1'b0; bus.axiid = 1'b0; bus.linbits = 4'd0; bus.axior = 1'b1;
    bus.tbl_we = 1'b0; bus.tbl_addr = '0; bus.tbl_code = '0; bus.tbl_len = 5'd0;
    bus.tbl_x = 4'd0; bus.tbl_y = 4'd0;
    tick(); tick(); tick();
    check("rst_axiov", {31'd0, bus.axiov}, 32'd0);
    check("rst_axiir", {31'd0, bus.axiir}, 32'd1);
    check("rst_x", {16'd0, bus.x_val}, 32'd0);
    check("rst_y", {16'd0, bus.y_val}, 32'd0);
    rst = 1'b0;

    // Empty table: four bits reach MAX_BITS and overflow without output.
    send_bits(16'b1000, 4);
    check("ovf_no_axiov", {31'd0, bus.axiov}, 32'd0);
`ifdef HT_CODE_ERR_EN
    check("ovf_err_hi", {31'd0, err}, 32'd1);
`endif
    tick();
`ifdef HT_CODE_ERR_EN
    check("ovf_err_lo", {31'd0, err}, 32'd0);
`endif
    check("ovf_still_idle", {31'd0, bus.axiov}, 32'd0);

    load_table();

    // (0,0) from the single bit "1".
    sb.push_back('{x: 16'd0, y: 16'd0});
    send_bits(16'b1, 1);
    check_pair("p00");
    tick();
    check("p00_consumed", {31'd0, bus.axiov}, 32'd0);

    // "001" (1,1), sign x = 1, sign y = 0.
    sb.push_back('{x: 16'hffff, y: 16'd1});
    send_bits(16'b00110, 5);
    check_pair("m1p1");
    tick();

    // linbits = 3: "01" (15,0), lin = 101 = 5, positive sign.
    bus.linbits = 4'd3;
    sb.push_back('{x: 16'd20, y: 16'd0});
    send_bits(16'b011010, 6);
    check_pair("lin20");
    tick();

    // linbits = 0: no extension bits, negative sign.
    bus.linbits = 4'd0;
    sb.push_back('{x: 16'hfff1, y: 16'd0});
    send_bits(16'b011, 3);
    check_pair("m15");
    tick();

    // Backpressure: the first pair is held for 5 cycles, then the second pair streams in.
    bus.axior = 1'b0;
    sb.push_back('{x: 16'hffff, y: 16'd1});
    send_bits(16'b00110, 5);
    check_pair("hold_first");
    for (int k = 0; k < 5; k++) begin
      tick();
      check("hold_axiov", {31'd0, bus.axiov}, 32'd1);
      check("hold_axiir", {31'd0, bus.axiir}, 32'd0);
      check("hold_x", {16'd0, bus.x_val}, 32'h0000ffff);
      check("hold_y", {16'd0, bus.y_val}, 32'd1);
    end
    bus.axior = 1'b1;
    bus.linbits = 4'd3;
    sb.push_back('{x: 16'd20, y: 16'd0});
    send_bits(16'b011010, 6);
    check_pair("second");
    tick();

    // A table write in the same cycle as a match: the match sees the old entry.
    bus.linbits = 4'd0;
    sb.push_back('{x: 16'd0, y: 16'd0});
    bus.axiiv = 1'b1; bus.axiid = 1'b1;
    bus.tbl_we = 1'b1; bus.tbl_addr = AW'(0); bus.tbl_code = 4'b1000;
    bus.tbl_len = 5'd1; bus.tbl_x = 4'd0; bus.tbl_y = 4'd1;
    tick();
    bus.axiiv = 1'b0; bus.tbl_we = 1'b0;
    check_pair("wr_old");
    tick();
    // The new entry is used from now on: (0,1) and then a positive y sign.
    sb.push_back('{x: 16'd0, y: 16'd1});
    send_bits(16'b10, 2);
    check_pair("wr_new");
    tick();

    // Reset in the middle of XLIN discards the pair.
    bus.linbits = 4'd3;
    send_bits(16'b011, 3);
    rst = 1'b1;
    bus.axiiv = 1'b1; bus.axiid = 1'b1;
    tick();
    bus.axiiv = 1'b0;
    check("rst_mid_axiov", {31'd0, bus.axiov}, 32'd0);
    check("rst_mid_axiir", {31'd0, bus.axiir}, 32'd1);
    check("rst_mid_y", {16'd0, bus.y_val}, 32'd0);
    rst = 1'b0;
    tick();
    check("rst_mid_idle", {31'd0, bus.axiov}, 32'd0);
    load_table();
    bus.linbits = 4'd0;
    sb.push_back('{x: 16'hfff1, y: 16'd0});
    send_bits(16'b011, 3);
    check_pair("after_rst");
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ht_pair_decoder.md
HT_PAIR_DECODER -- requirements
Module: ht_pair_decoder

Interface
REQ-001 Parameter MAX_BITS, default 19: longest codeword length in bits.
REQ-002 Parameter DEPTH, default 256: number of loadable code-table entries.
REQ-003 Port clk, input, 1: single clock; all logic on posedge.
REQ-004 Port rst, input, 1: reset, synchronous and active-high.
REQ-005 Port axiiv, input, 1: serial bit valid.
REQ-006 Port axiid, input, 1: serial bit, MSB-first codeword order.
REQ-007 Port axiir, output, 1: bit accepted when axiiv && axiir.
REQ-008 Port linbits, input, 4: escape extension width, 0..13.
REQ-009 Port tbl_we, input, 1: table entry write strobe.
REQ-010 Port tbl_addr, input, $clog2(DEPTH): entry index.
REQ-011 Port tbl_code, input, MAX_BITS: codeword, left-justified.
REQ-012 Port tbl_len, input, 5: codeword length; 0 marks the entry empty.
REQ-013 Port tbl_x / tbl_y, input, 4 each: absolute values 0..15.
REQ-014 Port axiov, output, 1: decoded pair valid.
REQ-015 Port axior, input, 1: downstream ready.
REQ-016 Port x_val / y_val, output, 16 signed each: decoded pair.

Function
REQ-017 State machine SHALL use states CODE, XLIN, XSGN, YLIN, YSGN, OUT.
REQ-018 Handshake: axiir = (state != OUT); SHALL consume only accepted bits.
REQ-019 CODE: each accepted bit SHALL shift into the buffer and increment bit count n.
REQ-020 Match: the buffer SHALL be compared the same cycle against all entries with tbl_len == n+1, including the incoming bit; lowest matching index wins.
REQ-021 On match, SHALL latch x_abs, y_abs, and linbits (sampled once per codeword), then go to the first applicable state among XLIN, XSGN, YLIN, YSGN, OUT.
REQ-022 XLIN/YLIN SHALL be entered only if abs == 15 and linbits > 0, and SHALL shift exactly linbits bits MSB-first into a 13-bit lin value.
REQ-023 XSGN/YSGN SHALL be entered only if abs+lin > 0; a sign bit of 1 means negative.
REQ-024 Value SHALL be abs + lin, zero-extended to 16 bits, two's-complement negated when sign = 1; range is ±8206.
REQ-025 Latency: axiov SHALL rise the cycle after the pair's final bit is accepted.
REQ-026 In OUT, x_val, y_val and axiov SHALL stay stable until axiov && axior; the next cycle SHALL be CODE with buffer, n, lin and signs cleared.
REQ-027 A pair (0,0) SHALL take codeword bits only.
REQ-028 If n reaches MAX_BITS without a match, the buffer and n SHALL clear and decoding SHALL restart at the next bit.
REQ-029 tbl_we SHALL write the entry at tbl_addr; the write SHALL affect matches from the next cycle, in any state.
REQ-030 If a write and a match hit the same cycle, the match SHALL use the old contents.

Reset
REQ-031 Under rst, state SHALL be CODE; axiov = 0, x_val = y_val = 0, axiir = 1; buffer, n, lin and signs SHALL clear.
REQ-032 rst SHALL dominate all other inputs, and an in-flight pair SHALL be discarded.
REQ-033 Table contents SHALL be cleared by rst, so every tbl_len = 0.

Configuration
REQ-034 With macro HT_CODE_ERR_EN defined, output port err (1 bit) SHALL pulse for one cycle on each REQ-028 overflow; reset value is 0.
REQ-035 Without HT_CODE_ERR_EN, port err SHALL not exist, and overflow recovery SHALL follow REQ-028 silently.

Verification
REQ-036 Table {0:"1"/1 → (0,0); 1:"001"/3 → (1,1); 2:"01"/2 → (15,0)} SHALL be the common setup for REQ-037 to REQ-041.
REQ-037 Bits 1 with axior=1 → axiov one cycle later, x=0, y=0.
REQ-038 Bits 0,0,1,1,0 → x = -1, y = +1.
REQ-039 linbits=3, bits 0,1,1,0,1,0 → x = +20, y = 0; with linbits=0, bits 0,1,1 → x = -15.
REQ-040 Two pairs streamed with axior held 0 for 5 cycles → first pair held stable and axiir = 0; second pair decoded correctly after release.
REQ-041 MAX_BITS=4, bits 0,0,0,0 → err pulse (HT_CODE_ERR_EN), no axiov; then bit 1 → (0,0).
REQ-042 rst asserted mid-XLIN → next cycle axiov = 0, state CODE; a fresh codeword decodes correctly.
